// File: rtl/resp_misr_checker_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : resp_misr_checker_pkg                                        |
// | Description : Shared FSM states, MISR defaults and fold width rule.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package resp_misr_checker_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_RUN    = 2'd1;
    localparam state_t ST_FINISH = 2'd2;

    localparam logic [31:0] DEFAULT_POLY = 32'h04C11DB7;
    localparam logic [31:0] DEFAULT_SEED = 32'hFFFFFFFF;

    // Number of SIG_W-wide slices once y is zero-padded up to a multiple of SIG_W.
    function automatic int fold_slices(input int y_w, input int sig_w);
        return (y_w + sig_w - 1) / sig_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/resp_misr_checker_misr_step.sv
// +----------------------------------------------------------------------------+
// | Module      : misr_step                                                    |
// | Description : Combinational next-signature: shift/feedback plus fold(y).   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module misr_step
    import resp_misr_checker_pkg::*;
#(
    parameter int               Y_W   = 199,
    parameter int               SIG_W = 32,
    parameter logic [SIG_W-1:0] POLY  = DEFAULT_POLY
) (
    input  logic [SIG_W-1:0] sig,
    input  logic [Y_W-1:0]   y,
    output logic [SIG_W-1:0] sig_next
);

    localparam int N_SLICES = fold_slices(Y_W, SIG_W);
    localparam int PAD_W    = N_SLICES * SIG_W;

    logic [PAD_W-1:0] y_pad;
    logic [SIG_W-1:0] fold;

    always_comb begin
        y_pad = PAD_W'(y);
        fold  = '0;
        for (int i = 0; i < N_SLICES; i++) begin
            fold = fold ^ y_pad[i*SIG_W +: SIG_W];
        end
    end

    assign sig_next = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ fold;

endmodule

`default_nettype wire

// File: rtl/resp_misr_checker.sv
// +----------------------------------------------------------------------------+
// | Module      : resp_misr_checker                                            |
// | Description : Absorbs num_vec response words into a MISR, compares result. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module resp_misr_checker
    import resp_misr_checker_pkg::*;
#(
    parameter int               Y_W   = 199,
    parameter int               SIG_W = 32,
    parameter logic [SIG_W-1:0] POLY  = DEFAULT_POLY,
    parameter logic [SIG_W-1:0] SEED  = DEFAULT_SEED,
    parameter int               CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic [SIG_W-1:0] exp_sig,
    input  logic [Y_W-1:0]   y,
    input  logic             y_vld,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] sig,
    output logic [CNT_W-1:0] count
);

    state_t           state_q, state_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [SIG_W-1:0] exp_q, exp_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [SIG_W-1:0] sig_step;

    misr_step #(
        .Y_W   (Y_W),
        .SIG_W (SIG_W),
        .POLY  (POLY)
    ) u_misr_step (
        .sig      (sig_q),
        .y        (y),
        .sig_next (sig_step)
    );

    // done/pass are launched on the edge entering FINISH so they line up with it.
    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        count_d = count_q;
        num_d   = num_q;
        exp_d   = exp_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sig_d   = SEED;
                    count_d = '0;
                    num_d   = num_vec;
                    exp_d   = exp_sig;
                    if (num_vec == '0) begin
                        state_d = ST_FINISH;
                        done_d  = 1'b1;
                        pass_d  = (SEED == exp_sig);
                    end else begin
                        state_d = ST_RUN;
                        pass_d  = 1'b0;
                    end
                end
            end
            ST_RUN: begin
                if (y_vld) begin
                    sig_d   = sig_step;
                    count_d = count_q + 1'b1;
                    if ((count_q + 1'b1) == num_q) begin
                        state_d = ST_FINISH;
                        done_d  = 1'b1;
                        pass_d  = (sig_step == exp_q);
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sig_q   <= SEED;
            count_q <= '0;
            num_q   <= '0;
            exp_q   <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            count_q <= count_d;
            num_q   <= num_d;
            exp_q   <= exp_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign busy  = (state_q != ST_IDLE);
    assign done  = done_q;
    assign pass  = pass_q;
    assign sig   = sig_q;
    assign count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_resp_misr_checker.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_resp_misr_checker                                         |
// | Description : Directed self-checking bench with hand-computed signatures.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_resp_misr_checker;

    localparam int Y_W   = 199;
    localparam int SIG_W = 32;
    localparam int CNT_W = 8;

    localparam logic [31:0] C_SEED = 32'hFFFFFFFF;
    localparam logic [31:0] C_S1   = 32'hFB3EE249;
    localparam logic [31:0] C_S2   = 32'hF2BCD925;
    localparam logic [31:0] C_S3   = 32'hE1B8AFFD;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] num_vec;
    logic [SIG_W-1:0] exp_sig;
    logic [Y_W-1:0]   y;
    logic             y_vld;
    logic             busy;
    logic             done;
    logic             pass;
    logic [SIG_W-1:0] sig;
    logic [CNT_W-1:0] count;

    int n_chk  = 0;
    int n_pass = 0;

    resp_misr_checker #(
        .Y_W   (Y_W),
        .SIG_W (SIG_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .num_vec (num_vec),
        .exp_sig (exp_sig),
        .y       (y),
        .y_vld   (y_vld),
        .busy    (busy),
        .done    (done),
        .pass    (pass),
        .sig     (sig),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Outputs are sampled 1ns after the rising edge; inputs change at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [CNT_W-1:0] n, input logic [SIG_W-1:0] e);
        start   = 1'b1;
        num_vec = n;
        exp_sig = e;
        tick();
        start   = 1'b0;
    endtask

    // One-word run; checks the completion cycle and the return to idle.
    task automatic one_word(input string tag, input logic [Y_W-1:0] w,
                            input logic [SIG_W-1:0] e, input logic [SIG_W-1:0] want_sig,
                            input logic want_pass);
        do_start(8'd1, e);
        y     = w;
        y_vld = 1'b1;
        tick();
        y_vld = 1'b0;
        check({tag, "_sig"},  64'(sig),  64'(want_sig));
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_pass"}, 64'(pass), 64'(want_pass));
        tick();
        check({tag, "_done_low"}, 64'(done), 64'd0);
        check({tag, "_idle"},     64'(busy), 64'd0);
    endtask

    initial begin
        logic [Y_W-1:0] w;

        rst_n   = 1'b0;
        start   = 1'b0;
        num_vec = '0;
        exp_sig = '0;
        y       = '0;
        y_vld   = 1'b0;
        #12;
        check("rst_busy",  64'(busy),  64'd0);
        check("rst_done",  64'(done),  64'd0);
        check("rst_pass",  64'(pass),  64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_sig",   64'(sig),   64'(C_SEED));
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Zero-length run: FINISH straight from start.
        do_start(8'd0, C_SEED);
        check("nv0_done", 64'(done), 64'd1);
        check("nv0_busy", 64'(busy), 64'd1);
        check("nv0_pass", 64'(pass), 64'd1);
        check("nv0_sig",  64'(sig),  64'(C_SEED));
        tick();
        check("nv0_done_low", 64'(done), 64'd0);
        check("nv0_idle",     64'(busy), 64'd0);
        check("nv0_pass_hold", 64'(pass), 64'd1);
        do_start(8'd0, 32'h0);
        check("nv0_bad_pass", 64'(pass), 64'd0);
        tick();

        one_word("w0_good", '0, C_S1, C_S1, 1'b1);
        one_word("w0_bad",  '0, 32'h0, C_S1, 1'b0);
        w = '0; w[32] = 1'b1;
        one_word("b32", w, 32'hFB3EE248, 32'hFB3EE248, 1'b1);
        w = '0; w[198] = 1'b1;
        one_word("b198", w, 32'h0, 32'hFB3EE209, 1'b0);
        w = '0; w[0] = 1'b1; w[32] = 1'b1;
        one_word("cancel", w, C_S1, C_S1, 1'b1);

        // y_vld in IDLE must not disturb the held result.
        y = '1; y_vld = 1'b1;
        tick();
        y_vld = 1'b0; y = '0;
        check("idle_vld_sig",   64'(sig),   64'(C_S1));
        check("idle_vld_count", 64'(count), 64'd1);

        // Three words with gaps, plus a stray start mid-run.
        do_start(8'd3, C_S3);
        y_vld = 1'b1;
        tick();
        y_vld = 1'b0;
        check("gap_cnt1", 64'(count), 64'd1);
        start = 1'b1; num_vec = 8'd0;
        tick();
        start = 1'b0;
        tick();
        check("gap_stall_cnt",  64'(count), 64'd1);
        check("gap_stall_sig",  64'(sig),   64'(C_S1));
        check("gap_stall_busy", 64'(busy),  64'd1);
        y_vld = 1'b1;
        tick();
        y_vld = 1'b0;
        check("gap_cnt2", 64'(count), 64'd2);
        check("gap_sig2", 64'(sig),   64'(C_S2));
        tick();
        check("gap_nodone", 64'(done), 64'd0);
        check("gap_busy2",  64'(busy), 64'd1);
        y_vld = 1'b1;
        tick();
        y_vld = 1'b0;
        check("gap_cnt3", 64'(count), 64'd3);
        check("gap_sig3", 64'(sig),   64'(C_S3));
        check("gap_done", 64'(done),  64'd1);
        check("gap_pass", 64'(pass),  64'd1);
        tick();
        check("gap_idle", 64'(busy), 64'd0);

        // Asynchronous reset in the middle of a run.
        do_start(8'd5, 32'h0);
        y_vld = 1'b1;
        tick();
        tick();
        y_vld = 1'b0;
        check("mid_cnt2", 64'(count), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy",  64'(busy),  64'd0);
        check("arst_count", 64'(count), 64'd0);
        check("arst_sig",   64'(sig),   64'(C_SEED));
        check("arst_done",  64'(done),  64'd0);
        check("arst_pass",  64'(pass),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        one_word("post_rst", '0, C_S1, C_S1, 1'b1);

        // Full-range count must not wrap.
        do_start(8'd255, 32'h0);
        y_vld = 1'b1;
        for (int i = 0; i < 254; i++) tick();
        check("max_cnt254",  64'(count), 64'd254);
        check("max_busy254", 64'(busy),  64'd1);
        check("max_nodone",  64'(done),  64'd0);
        tick();
        y_vld = 1'b0;
        check("max_cnt255", 64'(count), 64'd255);
        check("max_done",   64'(done),  64'd1);
        tick();
        check("max_idle", 64'(busy),  64'd0);
        check("max_hold", 64'(count), 64'd255);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
